// File: rtl/stream_pkg.sv
// Shared definitions for the valid/ready byte-stream blocks: default widths and
// the sink checker state encoding.
package stream_pkg;

    localparam int unsigned STREAM_DATA_W = 8;
    localparam int unsigned STREAM_CNT_W  = 16;
    localparam int unsigned STREAM_PAT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_STALL  = 2'd2,
        ST_DONE   = 2'd3
    } sink_state_e;

    function automatic logic state_is_busy(sink_state_e s);
        return (s == ST_ACCEPT) || (s == ST_STALL);
    endfunction

endpackage

// File: rtl/ready_pattern_gen.sv
// Run/stall cycle counters that pace the sink's ready signal: run_len ready
// cycles followed by stall_len not-ready cycles, repeating.
module ready_pattern_gen
    import stream_pkg::*;
#(
    parameter int unsigned PAT_W = STREAM_PAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PAT_W-1:0] run_len,
    input  logic [PAT_W-1:0] stall_len,
    input  logic             enable,
    input  logic             clear,
    output logic             stall_now,
    output logic             resume_now
);

    logic [PAT_W-1:0] cnt_q, cnt_d;
    logic             stalling_q, stalling_d;
    logic             pattern_on;

    always_comb begin
        pattern_on = (run_len != '0) && (stall_len != '0);
        stall_now  = enable && pattern_on && !stalling_q && (cnt_q == run_len - PAT_W'(1));
        resume_now = enable && stalling_q && (cnt_q == stall_len - PAT_W'(1));

        cnt_d      = cnt_q;
        stalling_d = stalling_q;
        if (clear) begin
            cnt_d      = '0;
            stalling_d = 1'b0;
        end else if (enable) begin
            if (stall_now) begin
                cnt_d      = '0;
                stalling_d = 1'b1;
            end else if (resume_now) begin
                cnt_d      = '0;
                stalling_d = 1'b0;
            end else if (pattern_on) begin
                cnt_d = cnt_q + PAT_W'(1);
            end
            // With the pattern off the counter parks at zero: ready never drops.
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            stalling_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            stalling_q <= stalling_d;
        end
    end

endmodule

// File: rtl/stream_sink_checker.sv
// Stream sink with programmable backpressure; checks that accepted words form an
// incrementing sequence and reports word/error counts and the first mismatch.
module stream_sink_checker
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = STREAM_DATA_W,
    parameter int unsigned CNT_W  = STREAM_CNT_W,
    parameter int unsigned PAT_W  = STREAM_PAT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] first_value,
    input  logic [PAT_W-1:0]  run_len,
    input  logic [PAT_W-1:0]  stall_len,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
);

    sink_state_e       state_q, state_d;
    logic [CNT_W-1:0]  num_words_q, num_words_d;
    logic [PAT_W-1:0]  run_len_q, run_len_d;
    logic [PAT_W-1:0]  stall_len_q, stall_len_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_flag_q, err_flag_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;

    logic xfer, mismatch, last_xfer;
    logic pat_enable, pat_clear, stall_now, resume_now;

    assign pat_enable = state_is_busy(state_q);
    assign pat_clear  = !state_is_busy(state_q);

    ready_pattern_gen #(
        .PAT_W (PAT_W)
    ) u_pattern (
        .clock      (clock),
        .reset      (reset),
        .run_len    (run_len_q),
        .stall_len  (stall_len_q),
        .enable     (pat_enable),
        .clear      (pat_clear),
        .stall_now  (stall_now),
        .resume_now (resume_now)
    );

    always_comb begin
        xfer      = r_valid && (state_q == ST_ACCEPT);
        mismatch  = xfer && (r_data != expected_q);
        last_xfer = xfer && ((word_count_q + CNT_W'(1)) == num_words_q);

        state_d      = state_q;
        num_words_d  = num_words_q;
        run_len_d    = run_len_q;
        stall_len_d  = stall_len_q;
        expected_d   = expected_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        err_data_d   = err_data_q;
        err_exp_d    = err_exp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_words_d  = num_words;
                    run_len_d    = run_len;
                    stall_len_d  = stall_len;
                    expected_d   = first_value;
                    word_count_d = '0;
                    err_count_d  = '0;
                    err_flag_d   = 1'b0;
                    err_data_d   = '0;
                    err_exp_d    = '0;
                    state_d      = (num_words == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                // Completion wins over the run counter expiring on the same edge.
                if (last_xfer) begin
                    state_d = ST_DONE;
                end else if (stall_now) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (resume_now) begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            word_count_d = word_count_q + CNT_W'(1);
            expected_d   = expected_q + DATA_W'(1);
            if (mismatch) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!err_flag_q) begin
                    err_flag_d = 1'b1;
                    err_data_d = r_data;
                    err_exp_d  = expected_q;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_words_q  <= '0;
            run_len_q    <= '0;
            stall_len_q  <= '0;
            expected_q   <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            err_data_q   <= '0;
            err_exp_q    <= '0;
        end else begin
            state_q      <= state_d;
            num_words_q  <= num_words_d;
            run_len_q    <= run_len_d;
            stall_len_q  <= stall_len_d;
            expected_q   <= expected_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            err_data_q   <= err_data_d;
            err_exp_q    <= err_exp_d;
        end
    end

    assign r_ready        = (state_q == ST_ACCEPT);
    assign busy           = state_is_busy(state_q);
    assign done           = (state_q == ST_DONE);
    assign word_count     = word_count_q;
    assign err_count      = err_count_q;
    assign err_flag       = err_flag_q;
    assign first_err_data = err_data_q;
    assign first_err_exp  = err_exp_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Randomized bench for stream_sink_checker: a behavioural source and sequence
// model predict the ready pattern, counts and first-mismatch captures.
module tb_stream_sink_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic [7:0]  first_value;
    logic [3:0]  run_len;
    logic [3:0]  stall_len;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic        err_flag;
    logic [7:0]  first_err_data;
    logic [7:0]  first_err_exp;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] src_q[$];

    always #5 clock = ~clock;

    stream_sink_checker dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .num_words      (num_words),
        .first_value    (first_value),
        .run_len        (run_len),
        .stall_len      (stall_len),
        .r_valid        (r_valid),
        .r_data         (r_data),
        .r_ready        (r_ready),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count),
        .err_count      (err_count),
        .err_flag       (err_flag),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_idle_cleared(input string tag);
        check({tag, "_r_ready"}, r_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_err_flag"}, err_flag, 0);
        check({tag, "_err_data"}, first_err_data, 0);
        check({tag, "_err_exp"}, first_err_exp, 0);
    endtask

    // One check run. The model: ready is high in cycle k (k=0 is the first cycle
    // after start) iff the pattern is off or k mod (R+S) < R; every cycle where the
    // source offers a word while ready is high consumes it and compares it
    // against first+index.
    task automatic run_check(input int num, input logic [7:0] first, input int rl,
                             input int sl, input int valid_pct, input int inject_k,
                             input int hold_lo, input int hold_hi, input int abort_after);
        int         k, accepted, errs;
        logic [7:0] exp_v, d, cap_d, cap_e;
        logic       flag, model_ready;
        bit         ended;
        accepted = 0; errs = 0; exp_v = first; flag = 0; cap_d = 0; cap_e = 0;

        @(negedge clock);
        start = 1; num_words = num[15:0]; first_value = first;
        run_len = rl[3:0]; stall_len = sl[3:0];
        @(posedge clock);
        #1 start = 0;

        if (num == 0) begin
            @(negedge clock);
            check("zero_done", done, 1);
            check("zero_ready", r_ready, 0);
            check("zero_busy", busy, 0);
            @(negedge clock);
            check("zero_done_end", done, 0);
            check("zero_ready_end", r_ready, 0);
            check("zero_word_count", word_count, 0);
            return;
        end

        k = 0; ended = 0;
        while (!ended) begin
            @(negedge clock);
            model_ready = (rl == 0 || sl == 0) ? 1'b1 : ((k % (rl + sl)) < rl);
            check("r_ready", r_ready, model_ready);
            check("busy", busy, 1);
            check("run_word_count", word_count, accepted);
            check("run_err_count", err_count, errs);
            start = (k == inject_k);
            if (start) begin
                first_value = ~first;
                num_words   = 16'd1;
            end
            r_valid = (src_q.size() > 0) && !(k >= hold_lo && k < hold_hi)
                      && (int'($urandom_range(99)) < valid_pct);
            r_data  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
            @(posedge clock);
            if (r_valid && model_ready) begin
                d = src_q.pop_front();
                accepted++;
                if (d != exp_v) begin
                    if (errs < 65535) errs++;
                    if (!flag) begin
                        flag = 1; cap_d = d; cap_e = exp_v;
                    end
                end
                exp_v = exp_v + 8'd1;
            end
            k++;
            if (accepted == num) begin
                ended = 1;
            end else if (abort_after != 0 && accepted == abort_after) begin
                @(negedge clock);
                reset = 1; start = 1; r_valid = 1;
                @(posedge clock);
                @(negedge clock);
                check_idle_cleared("abort");
                reset = 0; start = 0; r_valid = 0;
                @(negedge clock);
                check("abort_busy_after", busy, 0);
                check("abort_ready_after", r_ready, 0);
                return;
            end else if (k > 3000) begin
                check("budget_words", accepted, num);
                r_valid = 0; start = 0;
                return;
            end
        end

        @(negedge clock);
        start = 0; r_valid = 0;
        check("end_done", done, 1);
        check("end_ready", r_ready, 0);
        check("end_busy", busy, 0);
        check("end_word_count", word_count, num);
        check("end_err_count", err_count, errs);
        check("end_err_flag", err_flag, flag);
        check("end_err_data", first_err_data, cap_d);
        check("end_err_exp", first_err_exp, cap_e);
        @(negedge clock);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("hold_word_count", word_count, num);
        check("hold_err_count", err_count, errs);
    endtask

    task automatic fill_seq(input int n, input logic [7:0] first, input int err_1_in);
        logic [7:0] v;
        src_q.delete();
        v = first;
        for (int i = 0; i < n; i++) begin
            if (err_1_in != 0 && $urandom_range(err_1_in - 1) == 0) src_q.push_back(8'($urandom));
            else src_q.push_back(v);
            v = v + 8'd1;
        end
    endtask

    initial begin
        int         n, rl, sl, pct;
        logic [7:0] f;
        reset = 1; start = 0; num_words = 0; first_value = 0;
        run_len = 0; stall_len = 0; r_valid = 0; r_data = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_cleared("reset");
        reset = 0;

        // Continuous ready, clean 1..10.
        fill_seq(10, 8'd1, 0);
        run_check(10, 8'd1, 0, 0, 100, -1, 0, 0, 0);

        // Run 2 / stall 5, second word wrong: expect capture FF vs AB.
        src_q.delete();
        src_q.push_back(8'hAA);
        src_q.push_back(8'hFF);
        run_check(2, 8'hAA, 2, 5, 100, -1, 0, 1, 0);
        check("pat_err_count", err_count, 1);
        check("pat_err_data", first_err_data, 8'hFF);
        check("pat_err_exp", first_err_exp, 8'hAB);

        // Wrap FE, FF, 00, 01.
        fill_seq(4, 8'hFE, 0);
        run_check(4, 8'hFE, 0, 0, 100, -1, 0, 0, 0);

        // Zero-length run, then a start injected mid-run.
        src_q.delete();
        run_check(0, 8'h00, 0, 0, 100, -1, 0, 0, 0);
        fill_seq(6, 8'h10, 0);
        run_check(6, 8'h10, 1, 1, 100, 3, 0, 0, 0);

        // Reset after 3 of 8, then a clean run of 8.
        fill_seq(8, 8'h30, 0);
        run_check(8, 8'h30, 0, 0, 100, -1, 0, 0, 3);
        fill_seq(8, 8'h30, 0);
        run_check(8, 8'h30, 0, 0, 100, -1, 0, 0, 0);

        // Valid low for 20 cycles with run 3 / stall 1.
        fill_seq(12, 8'h50, 0);
        run_check(12, 8'h50, 3, 1, 100, -1, 4, 24, 0);

        // Randomized runs with sporadic corrupted words.
        for (int r = 0; r < 10; r++) begin
            n   = int'($urandom_range(25, 1));
            f   = 8'($urandom);
            rl  = int'($urandom_range(4));
            sl  = int'($urandom_range(4));
            pct = int'($urandom_range(100, 40));
            fill_seq(n, f, 6);
            run_check(n, f, rl, sl, pct, -1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
